morse_timing_ctrl: RTL

- Sequences the 1 ms LFSR timer and turns the raw Morse key into timed symbol events.
- Configures the timer for the selected clock mode and keeps it running.
- Counts ms ticks during key-down and key-up intervals and classifies each interval as dot, dash, letter end or word end.
- Presents one-entry buffered events, with a valid/ready handshake, to the downstream decoder.

---
 rtl/morse_pkg.sv | 13 +
 rtl/morse_timing_ctrl_if.sv | 8 +
 rtl/key_edge_sync.sv | 37 +++
 rtl/morse_timing_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: symbol codes, FSM states and timer mode helpers shared by the Morse timing controller
package morse_pkg;
  typedef enum logic [1:0] {S_CFG, S_GAP, S_PRESS} state_t;
  localparam logic [1:0] SYM_DOT = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LETTER = 2'b10;
  localparam logic [1:0] SYM_WORD = 2'b11;
  localparam logic [1:0] MODE_DEFAULT = 2'b01;
  localparam logic [1:0] MODE_ALIAS = 2'b10;
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_ALIAS) ? MODE_DEFAULT : m;
  endfunction
endpackage

// File: rtl/morse_timing_ctrl_if.sv
// morse_timing_ctrl_if: valid/ready symbol channel toward the downstream decoder
interface morse_timing_ctrl_if;
  logic sym_valid;
  logic sym_ready;
  logic [1:0] sym_code;
  modport master(output sym_valid, output sym_code, input sym_ready);
  modport slave(input sym_valid, input sym_code, output sym_ready);
endinterface

// File: rtl/key_edge_sync.sv
// key_edge_sync: 2-flop synchronizer with registered rise/fall pulses
module key_edge_sync (
  input  logic clock,
  input  logic rst,
  input  logic key_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, s3_q, rise_q, fall_q;
  logic s1_d, s2_d, s3_d, rise_d, fall_d;
  always_comb begin
    s1_d = key_in;
    s2_d = s1_q;
    s3_d = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level = s3_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/morse_timing_ctrl.sv
// morse_timing_ctrl: timer sequencing and key interval classification into buffered Morse symbol events
module morse_timing_ctrl
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int DOT_MAX_MS = 200,
  parameter int LETTER_GAP_MS = 400,
  parameter int WORD_GAP_MS = 1000,
  parameter int CNT_W = 11
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [1:0]                 cfg_mode,
  input  logic                       key_in,
  input  logic                       tmr_timeout,
  output logic                       tmr_enable,
  output logic                       tmr_reconfig,
  output logic [1:0]                 tmr_mode,
  morse_timing_ctrl_if.master        sym,
  output logic                       overflow,
  input  logic                       ovf_clr
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic letter_q, letter_d, word_q, word_d;
  logic en_q, en_d, rcfg_q, rcfg_d, valid_q, valid_d, ovf_q, ovf_d;
  logic [1:0] mode_q, mode_d, code_q, code_d, mode_n, ev_code;
  logic ev, key_lvl, key_rise, key_fall;
  key_edge_sync u_sync (
    .clock(clock),
    .rst(rst),
    .key_in(key_in),
    .level(key_lvl),
    .rise(key_rise),
    .fall(key_fall)
  );
  always_comb begin
    mode_n = norm_mode(cfg_mode);
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    state_d = state_q;
    cnt_d = cnt_q;
    letter_d = letter_q;
    word_d = word_q;
    mode_d = mode_q;
    en_d = 1'b1;
    rcfg_d = 1'b0;
    ev = 1'b0;
    ev_code = SYM_DOT;
    if (state_q == S_CFG) begin
      mode_d = mode_n;
      rcfg_d = 1'b1;
      en_d = 1'b0;
      cnt_d = '0;
      state_d = key_lvl ? S_PRESS : S_GAP;
    end else if (mode_n != mode_q) begin
      state_d = S_CFG;
      cnt_d = '0;
      letter_d = 1'b0;
      word_d = 1'b0;
    end else if (state_q == S_GAP && key_rise) begin
      cnt_d = '0;
      state_d = S_PRESS;
    end else if (state_q == S_PRESS && key_fall) begin
      cnt_d = '0;
      state_d = S_GAP;
      ev = cnt_q >= CNT_W'(DEBOUNCE_MS);
      ev_code = (cnt_q < CNT_W'(DOT_MAX_MS)) ? SYM_DOT : SYM_DASH;
      letter_d = letter_q | ev;
    end else if (tmr_timeout) begin
      cnt_d = cnt_inc;
      if (state_q == S_GAP && letter_q && cnt_inc == CNT_W'(LETTER_GAP_MS)) begin
        ev = 1'b1;
        ev_code = SYM_LETTER;
        letter_d = 1'b0;
        word_d = 1'b1;
      end else if (state_q == S_GAP && word_q && cnt_inc == CNT_W'(WORD_GAP_MS)) begin
        ev = 1'b1;
        ev_code = SYM_WORD;
        word_d = 1'b0;
      end
    end
    valid_d = valid_q & ~sym.sym_ready;
    code_d = code_q;
    ovf_d = ovf_q & ~ovf_clr;
    if (ev && !valid_d) begin
      valid_d = 1'b1;
      code_d = ev_code;
    end else if (ev) begin
      ovf_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_CFG;
      cnt_q <= '0;
      letter_q <= 1'b0;
      word_q <= 1'b0;
      mode_q <= MODE_DEFAULT;
      en_q <= 1'b0;
      rcfg_q <= 1'b0;
      valid_q <= 1'b0;
      code_q <= SYM_DOT;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      letter_q <= letter_d;
      word_q <= word_d;
      mode_q <= mode_d;
      en_q <= en_d;
      rcfg_q <= rcfg_d;
      valid_q <= valid_d;
      code_q <= code_d;
      ovf_q <= ovf_d;
    end
  end
  assign tmr_enable = en_q;
  assign tmr_reconfig = rcfg_q;
  assign tmr_mode = mode_q;
  assign sym.sym_valid = valid_q;
  assign sym.sym_code = code_q;
  assign overflow = ovf_q;
endmodule
